// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage register with an optional skid entry, flush and a
// saturating stall counter. It carries an opaque WIDTH-bit bundle with 1-cycle latency.
//   SKID=1: 2-entry FIFO (main + skid) with a registered in_ready.
//   SKID=0: 1-entry stage; in_ready is combinational from out_ready.
module pipe_stage_buf #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     SKID     = 1,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic drain;
  logic accept;

  // Head leaves at this edge; an empty stage ignores out_ready.
  assign drain  = main_valid_q & out_ready;
  // The skid variant registers in_ready so it never depends on out_ready.
  assign in_ready = (SKID != 0) ? in_ready_q : (~main_valid_q | out_ready);
  assign accept = in_valid & in_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = stall_cnt_q;

  // Next-state for the two storage entries, the registered in_ready and the stall counter.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Flush drops everything, including an input arriving at the same edge.
      main_valid_d = 1'b0;
      main_data_d  = RST_DATA;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        // Skid promotes to head; a new input queues behind it to keep FIFO order.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = in_data;
        end
      end else begin
        // Empty or pass-through: input lands straight in main, else main empties
        // while out_data keeps its last value.
        main_valid_d = accept;
        if (accept) begin
          main_data_d = in_data;
        end
      end
    end else if (accept) begin
      // Head is stalled, so the input parks in the skid entry.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end

    if (SKID == 0) begin
      skid_valid_d = 1'b0;
    end

    in_ready_d = ~(main_valid_d & skid_valid_d);

    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset discarding all held bundles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RST_DATA;
      skid_valid_q <= 1'b0;
      skid_data_q  <= RST_DATA;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance, each with its own reset,
// a FIFO reference model, directed scenarios and a randomized phase.
module tb_pipe_stage_buf;

  localparam int unsigned W      = 32;
  localparam int unsigned CW     = 4;
  localparam logic [W-1:0] RST_D = 32'hC0DE_0000;
  localparam int          SAT    = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned SK = (g == 0) ? 1 : 0;

    logic           rst_n;
    logic           in_valid, in_ready, out_valid, out_ready, flush;
    logic [W-1:0]   in_data, out_data;
    logic [1:0]     occupancy;
    logic [CW-1:0]  stall_cnt;
    bit             done = 1'b0;

    // Reference model: held bundles in order, idle out_data value, stall count.
    logic [W-1:0]   sb[$];
    logic [W-1:0]   idle_data = RST_D;
    int             stall_exp = 0;

    pipe_stage_buf #(
      .WIDTH   (W),
      .SKID    (SK),
      .CNT_W   (CW),
      .RST_DATA(RST_D)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .flush    (flush),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt)
    );

    // Reset empties the model immediately.
    always @(negedge rst_n) begin
      sb.delete();
      idle_data = RST_D;
      stall_exp = 0;
    end

    // Monitor: compare outputs against the model mid-cycle, then apply this edge's transfers.
    always @(negedge clk) begin
      int           n;
      logic         exp_ir;
      logic [W-1:0] exp_od;
      n      = sb.size();
      exp_ir = (SK != 0) ? (n < 2) : (n == 0 || out_ready);
      exp_od = (n > 0) ? sb[0] : idle_data;
      check($sformatf("d%0d out_valid", g), out_valid, (n > 0));
      check($sformatf("d%0d occupancy", g), occupancy, n);
      check($sformatf("d%0d in_ready", g), in_ready, exp_ir);
      check($sformatf("d%0d out_data", g), out_data, exp_od);
      check($sformatf("d%0d stall_cnt", g), stall_cnt, stall_exp);
      if (rst_n) begin
        if (n > 0 && !out_ready && stall_exp < SAT) stall_exp++;
        if (out_valid && out_ready) begin
          if (n == 0) check($sformatf("d%0d spurious output", g), out_data, idle_data ^ 1);
          else idle_data = sb.pop_front();
        end
        if (flush) begin
          sb.delete();
          idle_data = RST_D;
        end else if (in_valid && exp_ir) begin
          sb.push_back(in_data);
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #2;
    endtask

    task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
    endtask

    // Offer one bundle and return just after the edge that accepts it.
    task automatic push(input logic [W-1:0] d);
      logic acc;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        #1;
        acc = in_ready;
        tick();
        if (acc) begin
          in_valid = 1'b0;
          return;
        end
      end
      check($sformatf("d%0d push timeout", g), acc, 1);
      in_valid = 1'b0;
    endtask

    task automatic run_random(input int cycles);
      logic acc;
      logic fl;
      int   bias;
      bias = 2;
      for (int i = 0; i < cycles; i++) begin
        @(negedge clk);
        #1;
        acc = in_valid & in_ready;
        fl  = flush;
        tick();
        if (i % 48 == 0) bias = $urandom_range(0, 4);
        out_ready = ($urandom_range(0, 3) < bias);
        flush     = ($urandom_range(0, 19) == 0);
        if (!(in_valid && !acc && !fl)) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = $urandom;
        end
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
    endtask

    initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
    end

    if (g == 0) begin : g_skid_dir
      initial begin
        do_reset();
        // Streaming with downstream always ready.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
          push(W'(k));
          check("d0 stream occupancy", occupancy, 1);
        end
        tick();
        // Back-pressure fills both entries; C waits upstream.
        out_ready = 1'b0;
        push(32'hA);
        push(32'hB);
        in_valid = 1'b1;
        in_data  = 32'hC;
        tick();
        tick();
        check("d0 bp stall_cnt", stall_cnt, 3);
        check("d0 bp occupancy", occupancy, 2);
        check("d0 bp in_ready", in_ready, 0);
        check("d0 bp head", out_data, 32'hA);
        out_ready = 1'b1;
        push(32'hC);
        repeat (3) tick();
        // Flush while full with a simultaneous input.
        out_ready = 1'b0;
        push(32'h1A1);
        push(32'h1B1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("d0 flush out_valid", out_valid, 0);
        check("d0 flush occupancy", occupancy, 0);
        check("d0 flush in_ready", in_ready, 1);
        check("d0 flush out_data", out_data, RST_D);
        out_ready = 1'b1;
        repeat (3) tick();
        // Asynchronous reset mid-stream with both entries full.
        out_ready = 1'b0;
        push(32'h2A2);
        push(32'h2B2);
        #1;
        rst_n = 1'b0;
        #1;
        check("d0 rst out_valid", out_valid, 0);
        check("d0 rst occupancy", occupancy, 0);
        check("d0 rst in_ready", in_ready, 1);
        check("d0 rst stall_cnt", stall_cnt, 0);
        check("d0 rst out_data", out_data, RST_D);
        tick();
        rst_n = 1'b1;
        // Stall counter saturation.
        push(32'h55);
        repeat (20) tick();
        check("d0 sat stall_cnt", stall_cnt, SAT);
        repeat (2) tick();
        check("d0 sat hold", stall_cnt, SAT);
        out_ready = 1'b1;
        tick();
        run_random(700);
        done = 1'b1;
      end
    end else begin : g_pass_dir
      initial begin
        do_reset();
        // Combinational in_ready from out_ready with one entry held.
        out_ready = 1'b0;
        push(32'h11);
        in_valid = 1'b1;
        in_data  = 32'h22;
        #1;
        check("d1 in_ready blocked", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("d1 in_ready comb", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("d1 pass occupancy", occupancy, 1);
        check("d1 pass out_data", out_data, 32'h22);
        tick();
        for (int k = 1; k <= 8; k++) begin
          push(W'(k) + 32'h100);
          check("d1 stream occupancy", occupancy, 1);
        end
        tick();
        run_random(700);
        done = 1'b1;
      end
    end
  end

  initial begin
    bit finished;
    finished = 1'b0;
    for (int i = 0; i < 20000 && !finished; i++) begin
      @(posedge clk);
      finished = g_dut[0].done && g_dut[1].done;
    end
    check("overall completion", finished, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
